// File: rtl/iecdrv_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | iecdrv_pkg - shared types and helpers for the IEC drive ROM shadow      |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
package iecdrv_pkg;

  typedef enum logic {
    LOAD  = 1'b0,
    READY = 1'b1
  } iecdrv_rom_st_t;

  // Sets every bit below the highest set bit; turns a segment index into (pow2 size - 1).
  function automatic logic [31:0] smear_down(input logic [31:0] v);
    logic [31:0] r;
    r = v;
    for (int i = 0; i < 5; i++) begin
      r = r | (r >> (1 << i));
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/iecdrv_dpram.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | iecdrv_dpram - simple dual-port RAM, single clock, registered read      |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module iecdrv_dpram #(
  parameter int AW = 15,
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/iecdrv_rom_banked.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | iecdrv_rom_banked - banked drive-ROM shadow with blank-segment mirroring |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module iecdrv_rom_banked
  import iecdrv_pkg::*;
#(
  parameter int             AW     = 15,
  parameter int             DW     = 8,
  parameter int             BANKW  = 4,
  parameter int             SEGS   = 4,
  parameter logic [DW-1:0]  FILL   = 8'hFF,
  parameter bit             MIRROR = 1'b1
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic [BANKW-1:0] rom_bank,
  output logic             rom_req,
  output logic [AW-1:0]    rom_addr,
  input  logic             rom_wr,
  input  logic [DW-1:0]    rom_data,
  output logic             rom_valid,
  output logic [SEGS-1:0]  seg_empty,
  output logic [AW-1:0]    addr_mask,
  input  logic [AW-1:0]    mem_a,
  input  logic             mem_rd,
  output logic [DW-1:0]    rom_do,
  output logic             rom_do_vld
);

  localparam int SEGW = $clog2(SEGS);
  localparam int OFFW = AW - SEGW;

  iecdrv_rom_st_t   state_q;
  logic [AW-1:0]    addr_q;
  logic             valid_q;
  logic [SEGS-1:0]  seg_empty_q;
  logic [SEGS-1:0]  seg_empty_d;
  logic [AW-1:0]    mask_q;
  logic [AW-1:0]    mask_d;
  logic [BANKW-1:0] bank_q;
  logic             rd_fill_q;
  logic             rd_vld_q;
  logic [DW-1:0]    ram_rdata;

  logic             bank_chg;
  logic             wr_en;
  logic             word_used;
  logic [SEGW-1:0]  seg_idx;
  logic [SEGW-1:0]  k_hi;
  logic [SEGW-1:0]  size_m1;

  assign rom_req   = (state_q == LOAD) & ~reset;
  assign bank_chg  = (rom_bank != bank_q);
  assign wr_en     = rom_wr & rom_req & ~bank_chg;
  assign word_used = (rom_data != '0) && (rom_data != '1);
  assign seg_idx   = addr_q[AW-1 -: SEGW];

  // The word being written this cycle already counts toward the mask that
  // gets registered on the final write.
  always_comb begin
    seg_empty_d = seg_empty_q;
    if (wr_en && word_used) begin
      seg_empty_d[seg_idx] = 1'b0;
    end
  end

  always_comb begin
    k_hi = '0;
    for (int s = 0; s < SEGS; s++) begin
      if (!seg_empty_d[s]) begin
        k_hi = SEGW'(s);
      end
    end
    size_m1 = SEGW'(smear_down(32'(k_hi)));
    mask_d  = MIRROR ? {size_m1, {OFFW{1'b1}}} : '1;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= LOAD;
      addr_q      <= '0;
      valid_q     <= 1'b0;
      seg_empty_q <= '1;
      mask_q      <= '1;
      bank_q      <= rom_bank;
      rd_fill_q   <= 1'b1;
      rd_vld_q    <= 1'b0;
    end else begin
      rd_vld_q <= mem_rd;
      if (mem_rd) begin
        rd_fill_q <= ~valid_q;
      end

      if (bank_chg) begin
        state_q     <= LOAD;
        addr_q      <= '0;
        valid_q     <= 1'b0;
        seg_empty_q <= '1;
        mask_q      <= '1;
        bank_q      <= rom_bank;
      end else begin
        case (state_q)
          LOAD: begin
            if (wr_en) begin
              addr_q      <= addr_q + 1'b1;
              seg_empty_q <= seg_empty_d;
              if (addr_q == '1) begin
                state_q <= READY;
                valid_q <= 1'b1;
                mask_q  <= mask_d;
              end
            end
          end
          READY: begin
            state_q <= READY;
          end
          default: state_q <= LOAD;
        endcase
      end
    end
  end

  iecdrv_dpram #(
    .AW(AW),
    .DW(DW)
  ) u_ram (
    .clk_i  (clk_sys),
    .we_i   (wr_en),
    .waddr_i(addr_q),
    .wdata_i(rom_data),
    .re_i   (mem_rd & valid_q),
    .raddr_i(mem_a & mask_q),
    .rdata_o(ram_rdata)
  );

  assign rom_addr   = addr_q;
  assign rom_valid  = valid_q;
  assign seg_empty  = seg_empty_q;
  assign addr_mask  = mask_q;
  assign rom_do     = rd_fill_q ? FILL : ram_rdata;
  assign rom_do_vld = rd_vld_q;

endmodule
`default_nettype wire

// File: tb/tb_iecdrv_rom_banked.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_iecdrv_rom_banked - scoreboard bench for the banked drive-ROM shadow  |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module tb_iecdrv_rom_banked;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [3:0]  rom_bank;
  logic        rom_req;
  logic [14:0] rom_addr;
  logic        rom_wr;
  logic [7:0]  rom_data;
  logic        rom_valid;
  logic [3:0]  seg_empty;
  logic [14:0] addr_mask;
  logic [14:0] mem_a;
  logic        mem_rd;
  logic [7:0]  rom_do;
  logic        rom_do_vld;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [7:0] model [32768];
  logic [7:0] exp_q [$];
  int         cyc_q [$];

  iecdrv_rom_banked dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .rom_bank  (rom_bank),
    .rom_req   (rom_req),
    .rom_addr  (rom_addr),
    .rom_wr    (rom_wr),
    .rom_data  (rom_data),
    .rom_valid (rom_valid),
    .seg_empty (seg_empty),
    .addr_mask (addr_mask),
    .mem_a     (mem_a),
    .mem_rd    (mem_rd),
    .rom_do    (rom_do),
    .rom_do_vld(rom_do_vld)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Scoreboard monitor: every rom_do_vld pops one expected read.
  always @(negedge clk_sys) begin
    if (rom_do_vld) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_vld", 32'd1, 32'd0);
      end else begin
        logic [7:0] e;
        int         c;
        e = exp_q.pop_front();
        c = cyc_q.pop_front();
        chk("sb_rd_data", 32'(rom_do), 32'(e));
        chk("sb_rd_latency", 32'(cyc - c), 32'd1);
      end
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    rom_wr   = 1'b1;
    rom_data = d;
    model[a] = d;
    tick();
    rom_wr   = 1'b0;
  endtask

  task automatic rd(input logic [14:0] a, input logic [7:0] e);
    mem_a  = a;
    mem_rd = 1'b1;
    exp_q.push_back(e);
    cyc_q.push_back(cyc);
    tick();
    mem_rd = 1'b0;
  endtask

  function automatic logic [7:0] rnd_byte(input int a);
    logic [31:0] v;
    v = (a * 37) ^ (a >> 5) ^ 32'h3C;
    return v[7:0];
  endfunction

  function automatic logic [7:0] pat(input int a);
    logic [7:0] lo;
    lo = a[7:0];
    return lo ^ 8'h5A;
  endfunction

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [14:0] addrs [10];
    addrs = '{15'h0000, 15'h0001, 15'd100, 15'h005A, 15'h00A5,
              15'h1234, 15'h3FFF, 15'h4000, 15'h7FFF, 15'd20000};

    reset = 1'b1; rom_bank = 4'd3; rom_wr = 1'b0; rom_data = 8'h00;
    mem_a = '0; mem_rd = 1'b0;
    repeat (3) tick();
    chk("rst_req", 32'(rom_req), 32'd0);
    chk("rst_valid", 32'(rom_valid), 32'd0);
    chk("rst_seg_empty", 32'(seg_empty), 32'hF);
    chk("rst_mask", 32'(addr_mask), 32'h7FFF);
    chk("rst_addr", 32'(rom_addr), 32'd0);
    chk("rst_do", 32'(rom_do), 32'hFF);
    chk("rst_do_vld", 32'(rom_do_vld), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_req", 32'(rom_req), 32'd1);

    // 16K image in a 32K window: upper half blank (all 8'hFF)
    for (int a = 0; a < 32768; a++) wr(a, (a < 16384) ? rnd_byte(a) : 8'hFF);
    chk("t2_req", 32'(rom_req), 32'd0);
    chk("t2_valid", 32'(rom_valid), 32'd1);
    chk("t2_seg_empty", 32'(seg_empty), 32'hC);
    chk("t2_mask", 32'(addr_mask), 32'h3FFF);
    chk("t2_addr_wrap", 32'(rom_addr), 32'd0);
    rd(15'h4123, model[15'h0123]);
    rd(15'h0123, model[15'h0123]);
    rd(15'h7FFF, model[15'h3FFF]);
    rd(15'h2000, model[15'h2000]);
    tick(); tick();
    chk("t2_do_hold", 32'(rom_do), 32'(model[15'h2000]));

    // Bank change 3->5 with a read in the same cycle: old image still served
    rom_bank = 4'd5;
    rd(15'h0456, model[15'h0456]);
    chk("t3_valid", 32'(rom_valid), 32'd0);
    chk("t3_addr", 32'(rom_addr), 32'd0);
    chk("t3_req", 32'(rom_req), 32'd1);
    chk("t3_seg_empty", 32'(seg_empty), 32'hF);
    chk("t3_mask", 32'(addr_mask), 32'h7FFF);
    rd(15'h0123, 8'hFF);
    tick();

    // Bank change coinciding with the write at address 100
    for (int a = 0; a < 100; a++) wr(a, pat(a));
    chk("t4_addr100", 32'(rom_addr), 32'd100);
    rom_bank = 4'd6; rom_wr = 1'b1; rom_data = 8'h77;
    tick();
    rom_wr = 1'b0;
    chk("t4_addr_restart", 32'(rom_addr), 32'd0);
    chk("t4_req", 32'(rom_req), 32'd1);
    wr(0, pat(0));
    chk("t4_addr_after_one", 32'(rom_addr), 32'd1);
    rd(15'd5, 8'hFF);

    // Reset at address 20000 discards the partial load
    for (int a = 1; a < 20000; a++) wr(a, pat(a));
    chk("t5_addr20000", 32'(rom_addr), 32'd20000);
    reset = 1'b1;
    tick();
    chk("t5_rst_addr", 32'(rom_addr), 32'd0);
    chk("t5_rst_valid", 32'(rom_valid), 32'd0);
    chk("t5_rst_req", 32'(rom_req), 32'd0);
    reset = 1'b0;
    wr(0, pat(0));
    chk("t5_no_spurious_chg", 32'(rom_addr), 32'd1);

    // Full 32K image of addr^5A
    for (int a = 1; a < 32767; a++) wr(a, pat(a));
    chk("t1_req_before_last", 32'(rom_req), 32'd1);
    chk("t1_valid_before_last", 32'(rom_valid), 32'd0);
    wr(32767, pat(32767));
    chk("t1_req", 32'(rom_req), 32'd0);
    chk("t1_valid", 32'(rom_valid), 32'd1);
    chk("t1_seg_empty", 32'(seg_empty), 32'h0);
    chk("t1_mask", 32'(addr_mask), 32'h7FFF);
    chk("t1_addr_wrap", 32'(rom_addr), 32'd0);

    // Writes while READY are ignored
    rom_wr = 1'b1; rom_data = 8'h00;
    repeat (5) tick();
    rom_wr = 1'b0;
    chk("t6_addr", 32'(rom_addr), 32'd0);
    chk("t6_valid", 32'(rom_valid), 32'd1);
    for (int i = 0; i < 10; i++) rd(addrs[i], pat(int'(addrs[i])));
    repeat (3) tick();
    chk("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
